// File: rtl/asrm_uart_tx_fifo_if.sv
// Bus/core-side signal bundle for the UART transmit FIFO.
// master: CPU bus plus UART core (drives push/data/flush/end_transmit).
// slave : the FIFO itself.
interface asrm_uart_tx_fifo_if #(
  parameter int depth_log2 = 3
);
  logic                push;
  logic [7:0]          data_in;
  logic                flush;
  logic                full;
  logic                empty;
  logic [depth_log2:0] level;
  logic [7:0]          data_tx;
  logic                start_transmit;
  logic                end_transmit;
  logic                overflow;

  modport master (
    output push, data_in, flush, end_transmit,
    input  full, empty, level, data_tx, start_transmit, overflow
  );

  modport slave (
    input  push, data_in, flush, end_transmit,
    output full, empty, level, data_tx, start_transmit, overflow
  );
endinterface

// File: rtl/asrm_uart_tx_fifo.sv
// Byte transmit queue in front of the UART serial core.
// Holds start_transmit high while bytes are pending and pops one byte on
// each rising edge of the core's end_transmit. data_tx is registered and
// only changes on a pop or when arming, so it is stable across a frame.
// Optional macro ASRM_UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag
// for dropped pushes; without it overflow is tied low.
module asrm_uart_tx_fifo #(
  parameter int depth_log2 = 3
) (
  input logic                clk,
  input logic                reset,
  asrm_uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << depth_log2;
  localparam int LW    = depth_log2 + 1;

  typedef enum logic {IDLE, ARMED} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [7:0]            data_tx_q, data_tx_d;
  logic                  end_d_q;
  logic                  full, end_rise, pop, push_ok;

  assign full     = (level_q == LW'(DEPTH));
  assign end_rise = bus.end_transmit & ~end_d_q;
  assign pop      = end_rise & (state_q == ARMED);
  // A full queue still takes a byte when a slot frees up in the same cycle.
  assign push_ok  = bus.push & (~full | pop);

  // Next-state for pointers, level, FSM and the head-byte register.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    data_tx_d = data_tx_q;
    if (bus.flush) begin
      // data_tx deliberately left alone: the core may still be shifting it.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      state_d  = IDLE;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            state_d   = ARMED;
            data_tx_d = mem[rd_ptr_q];
          end
        end
        ARMED: begin
          if (pop) begin
            if (level_d == '0) begin
              state_d = IDLE;
            end else if (level_q == LW'(1)) begin
              // Only byte left is the one being pushed right now.
              data_tx_d = bus.data_in;
            end else begin
              data_tx_d = mem[rd_ptr_d];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      data_tx_q <= 8'h00;
      end_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      data_tx_q <= data_tx_d;
      end_d_q   <= bus.end_transmit;
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) mem[wr_ptr_q] <= bus.data_in;
  end

`ifdef ASRM_UART_TX_FIFO_OVERFLOW_EN
  logic ovf_q;
  // Sticky flag for bytes dropped on a full queue; cleared only by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          ovf_q <= 1'b0;
    else if (bus.flush)                  ovf_q <= 1'b0;
    else if (bus.push && full && !pop)   ovf_q <= 1'b1;
  end
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full           = full;
  assign bus.empty          = (level_q == '0);
  assign bus.level          = level_q;
  assign bus.data_tx        = data_tx_q;
  assign bus.start_transmit = (state_q == ARMED);
endmodule

// File: tb/tb_asrm_uart_tx_fifo.sv
// Directed bench for asrm_uart_tx_fifo: reset, single byte, fill/drain,
// drop on full, push during pop, and flush.
module tb_asrm_uart_tx_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef ASRM_UART_TX_FIFO_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  asrm_uart_tx_fifo_if #(.depth_log2(3)) bus ();

  asrm_uart_tx_fifo #(.depth_log2(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One end_transmit pulse: high 5 cycles, then low one cycle.
  task automatic pulse();
    bus.end_transmit = 1'b1;
    repeat (5) tick();
    bus.end_transmit = 1'b0;
    tick();
  endtask

  logic [7:0] exp4 [8];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.push = 1'b0;
    bus.data_in = 8'h00;
    bus.flush = 1'b0;
    bus.end_transmit = 1'b0;
    #12;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_data",  32'(bus.data_tx), 0);
    chk("rst_start", 32'(bus.start_transmit), 0);
    chk("rst_ovf",   32'(bus.overflow), 0);
    reset = 1'b1;
    tick();

    // Single byte
    bus.push = 1'b1; bus.data_in = 8'h41;
    tick();
    bus.push = 1'b0;
    chk("t1_level", 32'(bus.level), 1);
    chk("t1_empty", 32'(bus.empty), 0);
    chk("t1_start_n", 32'(bus.start_transmit), 0);
    tick();
    chk("t1_start", 32'(bus.start_transmit), 1);
    chk("t1_data", 32'(bus.data_tx), 32'h41);
    bus.end_transmit = 1'b1;
    tick();
    chk("t1_pop_level", 32'(bus.level), 0);
    chk("t1_pop_start", 32'(bus.start_transmit), 0);
    repeat (4) tick();
    chk("t1_hold_level", 32'(bus.level), 0);
    bus.end_transmit = 1'b0;
    tick();

    // Fill 01..08 and drain in order
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 8'(i);
      tick();
    end
    bus.push = 1'b0;
    chk("t2_full", 32'(bus.full), 1);
    chk("t2_level", 32'(bus.level), 8);
    chk("t2_start", 32'(bus.start_transmit), 1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_data", 32'(bus.data_tx), 32'(k + 1));
      pulse();
      chk("t2_level_d", 32'(bus.level), 32'(7 - k));
    end
    chk("t2_empty", 32'(bus.empty), 1);
    chk("t2_start_end", 32'(bus.start_transmit), 0);

    // Drop on full, then flush
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 8'(8'h10 + i);
      tick();
    end
    bus.data_in = 8'hFF;
    tick();
    bus.push = 1'b0;
    chk("t3_level", 32'(bus.level), 8);
    chk("t3_ovf", 32'(bus.overflow), 32'(EXP_OVF));
    chk("t3_data", 32'(bus.data_tx), 32'h11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_fl_level", 32'(bus.level), 0);
    chk("t3_fl_ovf", 32'(bus.overflow), 0);
    chk("t3_fl_start", 32'(bus.start_transmit), 0);
    chk("t3_fl_empty", 32'(bus.empty), 1);
    chk("t3_fl_data", 32'(bus.data_tx), 32'h11);

    // Full, push AA together with a pop
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.data_in = 8'(8'h20 + i);
      tick();
    end
    bus.push = 1'b0;
    chk("t4_head", 32'(bus.data_tx), 32'h21);
    bus.push = 1'b1; bus.data_in = 8'hAA; bus.end_transmit = 1'b1;
    tick();
    bus.push = 1'b0;
    chk("t4_level", 32'(bus.level), 8);
    chk("t4_ovf", 32'(bus.overflow), 0);
    repeat (4) tick();
    bus.end_transmit = 1'b0;
    tick();
    exp4[0] = 8'h22; exp4[1] = 8'h23; exp4[2] = 8'h24; exp4[3] = 8'h25;
    exp4[4] = 8'h26; exp4[5] = 8'h27; exp4[6] = 8'h28; exp4[7] = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      chk("t4_data", 32'(bus.data_tx), 32'(exp4[k]));
      pulse();
    end
    chk("t4_empty", 32'(bus.empty), 1);

    // Level 1, push 55 during the pop
    bus.push = 1'b1; bus.data_in = 8'h33;
    tick();
    bus.push = 1'b0;
    tick();
    chk("t5_head", 32'(bus.data_tx), 32'h33);
    bus.push = 1'b1; bus.data_in = 8'h55; bus.end_transmit = 1'b1;
    tick();
    bus.push = 1'b0;
    chk("t5_start", 32'(bus.start_transmit), 1);
    chk("t5_data", 32'(bus.data_tx), 32'h55);
    chk("t5_level", 32'(bus.level), 1);
    repeat (4) tick();
    bus.end_transmit = 1'b0;
    tick();
    chk("t5_start2", 32'(bus.start_transmit), 1);
    pulse();
    chk("t5_empty", 32'(bus.empty), 1);
    chk("t5_idle", 32'(bus.start_transmit), 0);

    // Flush with three bytes queued
    for (int i = 1; i <= 3; i++) begin
      bus.push = 1'b1; bus.data_in = 8'(8'h60 + i);
      tick();
    end
    bus.push = 1'b0;
    tick();
    chk("t6_level", 32'(bus.level), 3);
    chk("t6_head", 32'(bus.data_tx), 32'h61);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t6_fl_level", 32'(bus.level), 0);
    chk("t6_fl_start", 32'(bus.start_transmit), 0);
    chk("t6_fl_data", 32'(bus.data_tx), 32'h61);
    bus.end_transmit = 1'b1;
    tick();
    chk("t6_end_level", 32'(bus.level), 0);
    chk("t6_end_start", 32'(bus.start_transmit), 0);
    bus.end_transmit = 1'b0;
    tick();
    chk("t6_idle", 32'(bus.start_transmit), 0);
    chk("t6_data_keep", 32'(bus.data_tx), 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
